// File: rtl/uart_pkg.sv
// Shared definitions for the UART command sequencer and its ALU.
// - uart_state_e : one-hot sequencer state encoding
// - UartNbData   : default byte / operand width
// - Op*          : ALU opcodes (low 6 bits of the command's third byte)
package uart_pkg;

  localparam int unsigned UartNbData = 8;

  typedef enum logic [5:0] {
    StWaitA  = 6'b000001,
    StWaitB  = 6'b000010,
    StWaitOp = 6'b000100,
    StExec   = 6'b001000,
    StSend   = 6'b010000,
    StWaitTx = 6'b100000
  } uart_state_e;

  localparam logic [5:0] OpAdd = 6'h20;
  localparam logic [5:0] OpSub = 6'h22;
  localparam logic [5:0] OpAnd = 6'h24;
  localparam logic [5:0] OpOr  = 6'h25;
  localparam logic [5:0] OpXor = 6'h26;
  localparam logic [5:0] OpSra = 6'h03;
  localparam logic [5:0] OpSrl = 6'h02;
  localparam logic [5:0] OpNor = 6'h27;

endpackage

// File: rtl/uart_alu_timeout.sv
// Inter-byte timeout down-counter.
// Ports:
//   clk       system clock
//   i_rst_n   synchronous active-low reset (counter -> 0)
//   i_clear   reload with TIMEOUT_CYCLES-1 (wins over i_enable)
//   i_enable  count down while high
//   o_expire  high while enabled and the count has reached zero
// With TIMEOUT_CYCLES == 0 the expire output is tied low.
module uart_alu_timeout #(
  parameter int unsigned NB_TIMEOUT     = 20,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned LoadInt = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [NB_TIMEOUT-1:0] LoadVal = NB_TIMEOUT'(LoadInt);
  localparam bit Enabled = (TIMEOUT_CYCLES != 0);

  logic [NB_TIMEOUT-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_clear) begin
      cnt_q <= LoadVal;
    end else if (i_enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign o_expire = Enabled && i_enable && (cnt_q == '0);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Command sequencer between UART rx/tx and a combinational ALU.
// Collects operand A, operand B and opcode bytes, lets the ALU settle for
// one cycle, captures the result, pulses o_tx_start and waits for i_tx_done.
// Ports:
//   clk, i_rst_n     clock, synchronous active-low reset
//   i_rx_data/done   received byte and its one-cycle strobe
//   i_alu_result     combinational ALU output
//   i_tx_done        transmitter finished the frame
//   o_alu_a/b/op     operand and opcode registers driving the ALU
//   o_tx_data        captured result, o_tx_start one-cycle start pulse
//   o_busy           command in flight (EXEC/SEND/WAIT_TX)
//   o_timeout        pulse when a partial command is abandoned
//   o_drop_count     saturating count of bytes ignored while busy
module uart_alu_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned NB_DATA        = UartNbData,
  parameter int unsigned NB_OP          = 6,
  parameter int unsigned NB_TIMEOUT     = 20,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned NB_DROP        = 8
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout,
  output logic [NB_DROP-1:0] o_drop_count
);

  uart_state_e state_q, state_d;

  logic [NB_DATA-1:0] alu_a_q, alu_b_q, tx_data_q;
  logic [NB_OP-1:0]   alu_op_q;
  logic [NB_DROP-1:0] drop_q;
  logic               timeout_q;

  logic to_enable, to_clear, to_expire;
  logic busy;

  assign to_enable = (state_q == StWaitB) || (state_q == StWaitOp);
  // Any state change restarts the inter-byte window.
  assign to_clear  = (state_d != state_q);

  uart_alu_timeout #(
    .NB_TIMEOUT     (NB_TIMEOUT),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (to_clear),
    .i_enable (to_enable),
    .o_expire (to_expire)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q <= StWaitA;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a byte arriving on the expiry cycle takes priority.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitA:  if (i_rx_done) state_d = StWaitB;
      StWaitB: begin
        if (i_rx_done)      state_d = StWaitOp;
        else if (to_expire) state_d = StWaitA;
      end
      StWaitOp: begin
        if (i_rx_done)      state_d = StExec;
        else if (to_expire) state_d = StWaitA;
      end
      StExec:   state_d = StSend;
      StSend:   state_d = StWaitTx;
      StWaitTx: if (i_tx_done) state_d = StWaitA;
      default:  state_d = StWaitA;
    endcase
  end

  // Moore outputs
  always_comb begin
    o_tx_start = (state_q == StSend);
    busy       = (state_q == StExec) || (state_q == StSend) || (state_q == StWaitTx);
  end

  assign o_busy = busy;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      tx_data_q <= '0;
      drop_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= to_expire && !i_rx_done;
      if (i_rx_done) begin
        unique case (state_q)
          StWaitA:  alu_a_q  <= i_rx_data;
          StWaitB:  alu_b_q  <= i_rx_data;
          StWaitOp: alu_op_q <= i_rx_data[NB_OP-1:0];
          default:  ;
        endcase
      end
      if (state_q == StExec) begin
        tx_data_q <= i_alu_result;
      end
      if (busy && i_rx_done && (drop_q != '1)) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  assign o_alu_a      = alu_a_q;
  assign o_alu_b      = alu_b_q;
  assign o_alu_op     = alu_op_q;
  assign o_tx_data    = tx_data_q;
  assign o_timeout    = timeout_q;
  assign o_drop_count = drop_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
module tb_uart_alu_ctrl;
  import uart_pkg::*;

  localparam int unsigned TimeoutCycles = 16;

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [7:0] i_rx_data = '0;
  logic       i_rx_done = 1'b0;
  logic [7:0] i_alu_result;
  logic       i_tx_done = 1'b0;
  logic [7:0] o_alu_a, o_alu_b, o_tx_data, o_drop_count;
  logic [5:0] o_alu_op;
  logic       o_tx_start, o_busy, o_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  int exp_drop = 0;

  always #5 clk = ~clk;

  uart_alu_ctrl #(
    .NB_DATA        (8),
    .NB_OP          (6),
    .NB_TIMEOUT     (20),
    .TIMEOUT_CYCLES (TimeoutCycles),
    .NB_DROP        (8)
  ) dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_rx_data    (i_rx_data),
    .i_rx_done    (i_rx_done),
    .i_alu_result (i_alu_result),
    .i_tx_done    (i_tx_done),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_op     (o_alu_op),
    .o_tx_data    (o_tx_data),
    .o_tx_start   (o_tx_start),
    .o_busy       (o_busy),
    .o_timeout    (o_timeout),
    .o_drop_count (o_drop_count)
  );

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    logic [7:0] r;
    case (op)
      OpAdd:   r = a + b;
      OpSub:   r = a - b;
      OpAnd:   r = a & b;
      OpOr:    r = a | b;
      OpXor:   r = a ^ b;
      OpSra:   r = 8'($signed(a) >>> b[2:0]);
      OpSrl:   r = a >> b[2:0];
      OpNor:   r = ~(a | b);
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Environment ALU fed by the DUT's operand registers.
  always_comb i_alu_result = alu_model(o_alu_a, o_alu_b, o_alu_op);

  always @(posedge clk) if (o_tx_start === 1'b1) n_starts++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    step();
    i_rx_done = 1'b0;
  endtask

  // Sends a full command and stops once the DUT is waiting for tx_done.
  task automatic start_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input string tag);
    logic [7:0] exp;
    int         starts0;
    exp     = alu_model(a, b, opb[5:0]);
    starts0 = n_starts;
    send_byte(a);
    idle($urandom_range(0, 3));
    send_byte(b);
    idle($urandom_range(0, 3));
    send_byte(opb);
    check_eq({tag, ".a"}, 32'(o_alu_a), 32'(a));
    check_eq({tag, ".b"}, 32'(o_alu_b), 32'(b));
    check_eq({tag, ".op"}, 32'(o_alu_op), 32'(opb[5:0]));
    check_eq({tag, ".exec_busy"}, 32'(o_busy), 32'd1);
    check_eq({tag, ".exec_nostart"}, 32'(o_tx_start), 32'd0);
    step();
    check_eq({tag, ".start"}, 32'(o_tx_start), 32'd1);
    check_eq({tag, ".tx_data"}, 32'(o_tx_data), 32'(exp));
    step();
    check_eq({tag, ".start_once"}, 32'(o_tx_start), 32'd0);
    check_eq({tag, ".nstarts"}, 32'(n_starts - starts0), 32'd1);
    check_eq({tag, ".wait_busy"}, 32'(o_busy), 32'd1);
  endtask

  task automatic finish_cmd(input string tag);
    idle($urandom_range(0, 3));
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    check_eq({tag, ".idle"}, 32'(o_busy), 32'd0);
  endtask

  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         input string tag);
    start_cmd(a, b, opb, tag);
    finish_cmd(tag);
  endtask

  // Sends nbytes of a command, then stays silent until the timeout fires.
  task automatic expect_timeout(input int nbytes, input string tag);
    for (int i = 0; i < nbytes; i++) send_byte(8'h11 + 8'(i));
    for (int k = 1; k <= int'(TimeoutCycles); k++) begin
      step();
      if (k == int'(TimeoutCycles)) check_eq({tag, ".pulse"}, 32'(o_timeout), 32'd1);
      else if (o_timeout !== 1'b0) check_eq({tag, ".early"}, 32'(o_timeout), 32'd0);
    end
    step();
    check_eq({tag, ".single"}, 32'(o_timeout), 32'd0);
  endtask

  logic [5:0] ops [8] = '{OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSra, OpSrl, OpNor};

  initial begin
    int starts0;
    idle(2);
    check_eq("rst.a", 32'(o_alu_a), 32'd0);
    check_eq("rst.b", 32'(o_alu_b), 32'd0);
    check_eq("rst.op", 32'(o_alu_op), 32'd0);
    check_eq("rst.tx", 32'(o_tx_data), 32'd0);
    check_eq("rst.flags", {29'd0, o_tx_start, o_busy, o_timeout}, 32'd0);
    check_eq("rst.drop", 32'(o_drop_count), 32'd0);
    i_rst_n = 1'b1;
    step();

    run_cmd(8'h05, 8'h03, 8'h20, "basic");
    check_eq("basic.result", 32'(o_tx_data), 32'h08);
    run_cmd(8'hF0, 8'h0F, 8'hE5, "mask");
    check_eq("mask.op", 32'(o_alu_op), 32'h25);
    check_eq("mask.result", 32'(o_tx_data), 32'hFF);

    for (int i = 0; i < 20; i++) begin
      logic [7:0] opb;
      opb = {2'($urandom), ops[$urandom_range(0, 7)]};
      run_cmd(8'($urandom), 8'($urandom), opb, "rand");
    end

    expect_timeout(1, "to_b");
    run_cmd(8'h02, 8'h02, 8'h22, "after_to");
    check_eq("after_to.result", 32'(o_tx_data), 32'h00);
    expect_timeout(2, "to_op");

    // Byte arriving on the expiry cycle must be accepted.
    send_byte(8'h40);
    idle(int'(TimeoutCycles) - 1);
    send_byte(8'h09);
    check_eq("coll.no_to", 32'(o_timeout), 32'd0);
    check_eq("coll.b", 32'(o_alu_b), 32'h09);
    send_byte(OpSub);
    step();
    check_eq("coll.result", 32'(o_tx_data), 32'h37);
    step();
    finish_cmd("coll");

    start_cmd(8'h33, 8'h44, {2'b00, OpXor}, "drop");
    send_byte(8'hAA);
    send_byte(8'hBB);
    i_rx_data = 8'hCC;
    i_rx_done = 1'b1;
    i_tx_done = 1'b1;
    step();
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    exp_drop += 3;
    check_eq("drop.count", 32'(o_drop_count), 32'(exp_drop));
    check_eq("drop.a", 32'(o_alu_a), 32'h33);
    check_eq("drop.b", 32'(o_alu_b), 32'h44);
    check_eq("drop.op", 32'(o_alu_op), 32'(OpXor));
    check_eq("drop.tx", 32'(o_tx_data), 32'h77);
    check_eq("drop.idle", 32'(o_busy), 32'd0);

    start_cmd(8'h01, 8'h01, {2'b00, OpAdd}, "sat");
    for (int i = 0; i < 260; i++) begin
      send_byte(8'($urandom));
      exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
    end
    check_eq("sat.count", 32'(o_drop_count), 32'(exp_drop));
    check_eq("sat.a", 32'(o_alu_a), 32'h01);
    finish_cmd("sat");

    send_byte(8'h07);
    send_byte(8'h01);
    starts0 = n_starts;
    i_rst_n = 1'b0;
    step();
    i_rst_n = 1'b1;
    check_eq("mrst.a", 32'(o_alu_a), 32'd0);
    check_eq("mrst.b", 32'(o_alu_b), 32'd0);
    check_eq("mrst.op", 32'(o_alu_op), 32'd0);
    check_eq("mrst.tx", 32'(o_tx_data), 32'd0);
    check_eq("mrst.flags", {29'd0, o_tx_start, o_busy, o_timeout}, 32'd0);
    check_eq("mrst.drop", 32'(o_drop_count), 32'd0);
    idle(6);
    check_eq("mrst.nostart", 32'(n_starts - starts0), 32'd0);
    check_eq("mrst.busy", 32'(o_busy), 32'd0);
    run_cmd(8'h07, 8'h01, 8'h22, "post_rst");
    check_eq("post_rst.result", 32'(o_tx_data), 32'h06);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
- Command sequencer between the UART receiver/transmitter pair and the combinational ALU.
- Collects three bytes from the receiver, in order: operand A, operand B, opcode. Drives the ALU with them, captures the result, hands it to the transmitter and waits for transmission to finish.
- Adds an inter-byte timeout and a dropped-byte counter so a host that desynchronises the stream can recover.

Parameters:
- NB_DATA, 8, width of UART byte, operands and result
- NB_OP, 6, opcode width; opcode = low NB_OP bits of the third byte
- NB_TIMEOUT, 20, width of the inter-byte timeout counter
- TIMEOUT_CYCLES, 1000000, clk cycles allowed between bytes of one command; 0 disables timeout
- NB_DROP, 8, width of the dropped-byte counter

Ports:
- clk  in  1  system clock
- i_rst_n  in  1  reset; one clock, reset is synchronous and active-low
- i_rx_data  in  NB_DATA  byte from receiver, valid when i_rx_done=1
- i_rx_done  in  1  one-cycle pulse, byte available
- i_alu_result  in  NB_DATA  combinational ALU result
- i_tx_done  in  1  one-cycle pulse, transmitter finished frame
- o_alu_a  out  NB_DATA  operand A register
- o_alu_b  out  NB_DATA  operand B register
- o_alu_op  out  NB_OP  opcode register
- o_tx_data  out  NB_DATA  captured result for transmitter
- o_tx_start  out  1  one-cycle start pulse to transmitter
- o_busy  out  1  high in EXEC/SEND/WAIT_TX
- o_timeout  out  1  one-cycle pulse when a partial command is abandoned
- o_drop_count  out  NB_DROP  saturating count of ignored bytes

Behaviour:
- Reset (i_rst_n=0 at clk edge):
  - state=WAIT_A; all outputs and the timeout counter are 0.
  - Reset applied mid-command discards the partial command; no o_tx_start is issued afterwards.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX. Registered state, next-state logic separate.
- WAIT_A: on i_rx_done, o_alu_a<=i_rx_data, go to WAIT_B.
- WAIT_B: on i_rx_done, o_alu_b<=i_rx_data, go to WAIT_OP.
- WAIT_OP: on i_rx_done, o_alu_op<=i_rx_data[NB_OP-1:0], go to EXEC. Upper byte bits are ignored.
- EXEC: one cycle for the ALU to settle with stable operands. At its end o_tx_data<=i_alu_result, go to SEND.
- SEND: o_tx_start=1 for exactly this cycle (Moore output), then go to WAIT_TX.
- WAIT_TX: on i_tx_done, go to WAIT_A. Otherwise hold indefinitely (no timeout).
- Latency: if the opcode rx_done is sampled at edge N, then EXEC occupies N..N+1, SEND occupies N+1..N+2, and o_tx_start is high during the second cycle after the opcode pulse.
- o_alu_a/b/op and o_tx_data hold their values until overwritten by the next command.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter runs only in WAIT_B and WAIT_OP, and clears on every state change.
  - On reaching TIMEOUT_CYCLES-1 with no i_rx_done, go to WAIT_A and pulse o_timeout for 1 cycle.
  - If i_rx_done coincides with expiry, the byte wins: it is accepted and there is no timeout.
- Dropped bytes:
  - i_rx_done while in EXEC, SEND or WAIT_TX is ignored and increments o_drop_count, saturating at 2^NB_DROP-1.
  - i_rx_done coinciding with i_tx_done in WAIT_TX is dropped as well.
- Operand registers are never modified outside their WAIT_ state.

Decomposition:
- Shared package uart_pkg: state encoding (one-hot localparams), default NB_DATA, and the opcode constants used by the ALU (ADD=6'h20, SUB=6'h22, AND=6'h24, OR=6'h25, XOR=6'h26, SRA=6'h03, SRL=6'h02, NOR=6'h27).
- One natural sub-module: uart_alu_timeout, a loadable down-counter with enable, clear and an expire pulse.
- Keep the FSM and all registers in uart_alu_ctrl.

Test Plan:
- Basic command: bytes 0x05, 0x03, 0x20 with ALU model = ADD → o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20. o_tx_start pulses 2 cycles after the third rx_done, o_tx_data=0x08. After i_tx_done, o_busy=0 and state=WAIT_A.
- Opcode masking: bytes 0xF0, 0x0F, 0xE5 → o_alu_op=0x25, ALU OR result 0xFF on o_tx_data.
- Timeout: TIMEOUT_CYCLES=16, send 0x11 then nothing → o_timeout pulses once, 16 cycles after entering WAIT_B. Next bytes 0x02, 0x02, 0x22 → result 0x00 with A=0x02 (0x11 discarded).
- Timeout/rx collision: i_rx_done on the expiry cycle → no o_timeout, byte latched, state advances.
- Drops: 3 rx_done pulses while in WAIT_TX (one simultaneous with i_tx_done) → o_drop_count=3, no operand register changes. Preload 255 drops → count stays 255.
- Reset mid-command: after A=0x07, B=0x01, assert i_rst_n=0 for 1 cycle → all outputs 0, no o_tx_start. A subsequent full command executes normally.
